debug_frame_tx: RTL and testbench

Turns each change event from the switch debugger stage into one minimal raw Ethernet frame. The block sits directly downstream of the debugger: it consumes the debugger's `trigger` pulse and `data` byte. It then streams a 60-byte frame (headers, sequence number, sample, zero padding) over a byte-wide valid/ready interface to the MAC transmit path, which appends preamble and FCS. A one-entry pending slot absorbs a sample that arrives while a frame is in flight; further samples are dropped and counted.

---
 rtl/debug_frame_tx_if.sv | 10 +
 rtl/debug_frame_tx.sv | 135 +++++++++++++
 tb/tb_debug_frame_tx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/debug_frame_tx_if.sv
// Byte-wide valid/ready stream carrying debug frames towards the MAC transmit path.
interface debug_frame_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/debug_frame_tx.sv
// Wraps each debugger trigger/data event into a 60-byte raw Ethernet frame,
// with a one-entry pending slot and a saturating drop counter.
module debug_frame_tx #(
    parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic [7:0]       data,
    debug_frame_tx_if.master tx,
    output logic             busy,
    output logic [7:0]       drop_count
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [5:0] LAST_IDX = 6'd59;

    state_t     state, state_nxt;
    logic [5:0] idx, idx_nxt;
    logic [7:0] seq, seq_nxt;
    logic [7:0] cur, cur_nxt;
    logic       pend_v, pend_v_nxt;
    logic [7:0] pend_d, pend_d_nxt;
    logic [7:0] drop_nxt;
    logic       xfer;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [5:0] i, input logic [7:0] s,
                                              input logic [7:0] c);
        case (i)
            6'd0:    return DST_MAC[47:40];
            6'd1:    return DST_MAC[39:32];
            6'd2:    return DST_MAC[31:24];
            6'd3:    return DST_MAC[23:16];
            6'd4:    return DST_MAC[15:8];
            6'd5:    return DST_MAC[7:0];
            6'd6:    return SRC_MAC[47:40];
            6'd7:    return SRC_MAC[39:32];
            6'd8:    return SRC_MAC[31:24];
            6'd9:    return SRC_MAC[23:16];
            6'd10:   return SRC_MAC[15:8];
            6'd11:   return SRC_MAC[7:0];
            6'd12:   return ETHERTYPE[15:8];
            6'd13:   return ETHERTYPE[7:0];
            6'd14:   return s;
            6'd15:   return c;
            default: return 8'h00;
        endcase
    endfunction

    assign xfer = (state == SEND) && tx.tx_ready;

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        seq_nxt    = seq;
        cur_nxt    = cur;
        pend_v_nxt = pend_v;
        pend_d_nxt = pend_d;
        drop_nxt   = drop_count;
        case (state)
            IDLE: begin
                if (trigger) begin
                    cur_nxt   = data;
                    idx_nxt   = 6'd0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (xfer && idx == LAST_IDX) begin
                    seq_nxt = seq + 8'd1;
                    idx_nxt = 6'd0;
                    // Pending sample wins over a same-cycle trigger; an empty slot lets
                    // the trigger start the next frame directly with no idle gap.
                    if (pend_v) begin
                        cur_nxt    = pend_d;
                        pend_v_nxt = 1'b0;
                        if (trigger) drop_nxt = sat_inc(drop_count);
                    end else if (trigger) begin
                        cur_nxt = data;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    if (xfer) idx_nxt = idx + 6'd1;
                    if (trigger) begin
                        if (!pend_v) begin
                            pend_d_nxt = data;
                            pend_v_nxt = 1'b1;
                        end else begin
                            drop_nxt = sat_inc(drop_count);
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state and registered stream outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 6'd0;
            seq         <= 8'd0;
            pend_v      <= 1'b0;
            drop_count  <= 8'd0;
            tx.tx_valid <= 1'b0;
            tx.tx_last  <= 1'b0;
            tx.tx_data  <= 8'h00;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            seq         <= seq_nxt;
            pend_v      <= pend_v_nxt;
            drop_count  <= drop_nxt;
            tx.tx_valid <= (state_nxt == SEND);
            tx.tx_last  <= (state_nxt == SEND) && (idx_nxt == LAST_IDX);
            tx.tx_data  <= (state_nxt == SEND) ? frame_byte(idx_nxt, seq_nxt, cur_nxt) : 8'h00;
            busy        <= (state_nxt == SEND);
        end
    end

    // Sample holding registers carry no reset; they are only read once written.
    always_ff @(posedge clk) begin
        cur    <= cur_nxt;
        pend_d <= pend_d_nxt;
    end
endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench for debug_frame_tx: frame contents, backpressure, pending slot,
// same-cycle trigger, seq wrap / drop saturation and mid-frame reset.
module tb_debug_frame_tx;
    logic       clk = 1'b0;
    logic       reset;
    logic       trigger;
    logic [7:0] data;
    logic       busy;
    logic [7:0] drop_count;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] seq_m;
    logic [7:0] samp;

    debug_frame_tx_if tx_if ();

    debug_frame_tx dut (
        .clk        (clk),
        .reset      (reset),
        .trigger    (trigger),
        .data       (data),
        .tx         (tx_if),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_byte(input int i, input logic [7:0] s, input logic [7:0] d);
        if (i < 6) return 8'hFF;
        case (i)
            6, 11:   return (i == 6) ? 8'h02 : 8'h01;
            12:      return 8'h88;
            13:      return 8'hB5;
            14:      return s;
            15:      return d;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] d);
        @(negedge clk);
        tx_if.tx_ready = 1'b0;
        trigger = 1'b1;
        data = d;
        @(negedge clk);
        trigger = 1'b0;
        check("start_valid", {7'd0, tx_if.tx_valid}, 8'd1);
    endtask

    // Collects one 60-beat frame; injects ntrig triggers at beats 8/12/16 and an
    // optional trigger on the cycle the last beat transfers.
    task automatic recv_frame(input logic [7:0] eseq, input logic [7:0] esamp, input bit rnd,
                              input int ntrig, input logic [7:0] t0, input logic [7:0] t1,
                              input logic [7:0] t2, input bit ltrig, input logic [7:0] ldat);
        int beat = 0;
        int cyc = 0;
        int tf = 0;
        bit stalled = 0;
        logic [7:0] hold_d = 8'h00;
        logic hold_l = 1'b0;
        while (beat < 60 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            trigger = 1'b0;
            if (stalled) begin
                check($sformatf("stall_data_%0d", beat), tx_if.tx_data, hold_d);
                check($sformatf("stall_last_%0d", beat), {7'd0, tx_if.tx_last}, {7'd0, hold_l});
            end
            tx_if.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tf < ntrig && beat == 8 + 4 * tf) begin
                trigger = 1'b1;
                data = (tf == 0) ? t0 : (tf == 1) ? t1 : t2;
                tf++;
            end
            check($sformatf("valid_%0d", beat), {7'd0, tx_if.tx_valid}, 8'd1);
            check($sformatf("busy_%0d", beat), {7'd0, busy}, 8'd1);
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                check($sformatf("byte_%0d", beat), tx_if.tx_data, exp_byte(beat, eseq, esamp));
                check($sformatf("last_%0d", beat), {7'd0, tx_if.tx_last}, {7'd0, beat == 59});
                if (beat == 59 && ltrig) begin
                    trigger = 1'b1;
                    data = ldat;
                end
                beat++;
                stalled = 0;
            end else begin
                stalled = 1;
                hold_d = tx_if.tx_data;
                hold_l = tx_if.tx_last;
            end
        end
        if (beat < 60) begin
            tests++;
            fails++;
            $error("FAIL frame_timeout: observed %0d beats expected 60", beat);
        end
    endtask

    task automatic end_check(input bit exp_v);
        @(negedge clk);
        trigger = 1'b0;
        tx_if.tx_ready = 1'b0;
        check("gap_valid", {7'd0, tx_if.tx_valid}, {7'd0, exp_v});
        check("gap_busy", {7'd0, busy}, {7'd0, exp_v});
        if (exp_v) check("gap_byte0", tx_if.tx_data, 8'hFF);
    endtask

    initial begin
        reset = 1'b1;
        trigger = 1'b0;
        data = 8'h00;
        tx_if.tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", {7'd0, tx_if.tx_valid}, 8'd0);
        check("rst_last", {7'd0, tx_if.tx_last}, 8'd0);
        check("rst_data", tx_if.tx_data, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_drop", drop_count, 8'd0);

        // Single frame, then the same payload under random backpressure
        start_frame(8'hA5);
        recv_frame(8'd0, 8'hA5, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        end_check(0);
        start_frame(8'hA5);
        recv_frame(8'd1, 8'hA5, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        end_check(0);

        // Pending slot: 22 pends, 33 drops
        start_frame(8'h11);
        recv_frame(8'd2, 8'h11, 0, 2, 8'h22, 8'h33, 8'h00, 0, 8'h00);
        end_check(1);
        check("pend_drop", drop_count, 8'd1);
        recv_frame(8'd3, 8'h22, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        end_check(0);

        // Trigger on the last-beat cycle with an empty slot
        start_frame(8'hC3);
        recv_frame(8'd4, 8'hC3, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h5A);
        end_check(1);
        recv_frame(8'd5, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        end_check(0);
        check("same_cycle_drop", drop_count, 8'd1);

        // 300 chained frames, three triggers each: seq wraps, drops saturate
        seq_m = 8'd6;
        samp = 8'h00;
        start_frame(samp);
        for (int k = 0; k < 300; k++) begin
            recv_frame(seq_m, samp, 0, 3, 8'(k + 1), 8'hEE, 8'hEE, 0, 8'h00);
            end_check(1);
            seq_m = seq_m + 8'd1;
            samp = 8'(k + 1);
        end
        recv_frame(seq_m, samp, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        end_check(0);
        check("sat_seq_final", seq_m, 8'd50);
        check("sat_drop", drop_count, 8'd255);

        // Reset while beat 20 is on the bus
        start_frame(8'h77);
        begin
            int n = 0;
            int g = 0;
            while (n < 20 && g < 200) begin
                @(negedge clk);
                tx_if.tx_ready = 1'b1;
                if (tx_if.tx_valid) n++;
                g++;
            end
            check("pre_reset_beats", 8'(n), 8'd20);
        end
        @(negedge clk);
        tx_if.tx_ready = 1'b0;
        check("pre_reset_byte20", tx_if.tx_data, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_valid", {7'd0, tx_if.tx_valid}, 8'd0);
        check("mid_rst_last", {7'd0, tx_if.tx_last}, 8'd0);
        check("mid_rst_data", tx_if.tx_data, 8'h00);
        check("mid_rst_busy", {7'd0, busy}, 8'd0);
        check("mid_rst_drop", drop_count, 8'd0);
        start_frame(8'h99);
        recv_frame(8'd0, 8'h99, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        end_check(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
